// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipe_ctrl stall/flush scheduler.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned PERF_W          = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                  id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
                                  mem_wb_en: 1'b0, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_ALL_EN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
                                    mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_MEM_STALL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                       id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
                                       mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                   id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b0,
                                   mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

  // Normal-flow controls: branch redirect outranks a load-use stall.
  function automatic ctrl_t run_ctrl(input logic branch, input logic lu);
    ctrl_t c;
    c = CTRL_ALL_EN;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (lu) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the EX load and the ID sources.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_reg_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr_i,
  output logic                      lu_hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired, so a load targeting it never blocks a consumer.
  always_comb begin
    rs1_hit     = id_rs1_used_i && (id_rs1_addr_i == ex_reg_waddr_i);
    rs2_hit     = id_rs2_used_i && (id_rs2_addr_i == ex_reg_waddr_i);
    lu_hazard_o = ex_is_load_i && ex_reg_wen_i && (ex_reg_waddr_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage core; PIPE_CTRL_PERF_EN adds
// saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_reg_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr_i,
  input  logic                      ex_branch_taken_i,
  input  logic                      mem_req_i,
  input  logic                      mem_ack_i,
  input  logic                      wb_ebreak_i,
  output logic                      pc_en_o,
  output logic                      if_id_en_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_en_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_en_o,
  output logic                      mem_wb_en_o,
  output logic                      mem_wb_bubble_o,
  output logic                      halt_o,
  output logic                      fault_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_lu_stall_o,
  output logic [PERF_W-1:0]         perf_mem_wait_o,
  output logic [PERF_W-1:0]         perf_flush_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             lu_hazard;
  ctrl_t            ctrl;
  logic             halt_c;
  logic             fault_c;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard_detect (
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_reg_wen_i   (ex_reg_wen_i),
    .ex_reg_waddr_i (ex_reg_waddr_i),
    .lu_hazard_o    (lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    ctrl    = CTRL_IDLE;
    halt_c  = 1'b0;
    fault_c = fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (wb_ebreak_i) begin
          state_d = ST_HALT;
        end else if (mem_req_i && !mem_ack_i) begin
          ctrl    = CTRL_MEM_STALL;
          cnt_d   = CNT_W'(1);
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl = run_ctrl(ex_branch_taken_i, lu_hazard);
        end
      end
      ST_MEM_WAIT: begin
        // A late ack beats the timeout in the same cycle.
        if (mem_ack_i) begin
          ctrl    = run_ctrl(ex_branch_taken_i, lu_hazard);
          state_d = ST_RUN;
        end else if (cnt_q >= CNT_W'(MEM_TIMEOUT)) begin
          ctrl    = CTRL_MEM_STALL;
          halt_c  = 1'b1;
          fault_c = 1'b1;
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          ctrl  = CTRL_MEM_STALL;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        halt_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      ctrl    = CTRL_RESET;
      halt_c  = 1'b0;
      fault_c = 1'b0;
    end
  end

  assign pc_en_o         = ctrl.pc_en;
  assign if_id_en_o      = ctrl.if_id_en;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_ex_en_o      = ctrl.id_ex_en;
  assign id_ex_flush_o   = ctrl.id_ex_flush;
  assign ex_mem_en_o     = ctrl.ex_mem_en;
  assign mem_wb_en_o     = ctrl.mem_wb_en;
  assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
  assign halt_o          = halt_c;
  assign fault_o         = fault_c;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_lu_q, perf_mw_q, perf_fl_q;
  logic              lu_evt, br_evt, mw_evt;

  // Load-use keeps IF/ID un-flushed; a branch flushes IF/ID with the PC running.
  assign lu_evt = !rst && ctrl.id_ex_flush && !ctrl.if_id_flush;
  assign br_evt = !rst && ctrl.if_id_flush && ctrl.pc_en;
  assign mw_evt = (state_q == ST_MEM_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q <= '0;
      perf_mw_q <= '0;
      perf_fl_q <= '0;
    end else if (state_q != ST_HALT) begin
      if (lu_evt && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + PERF_W'(1);
      if (mw_evt && (perf_mw_q != '1)) perf_mw_q <= perf_mw_q + PERF_W'(1);
      if (br_evt && (perf_fl_q != '1)) perf_fl_q <= perf_fl_q + PERF_W'(1);
    end
  end

  assign perf_lu_stall_o = perf_lu_q;
  assign perf_mem_wait_o = perf_mw_q;
  assign perf_flush_o    = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic
// against a behavioural model of the scheduling rules.
module tb_pipe_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          is_load;
    logic          wen;
    logic [AW-1:0] waddr;
    logic          br;
    logic          req;
    logic          ack;
    logic          ebreak;
  } stim_t;

  typedef struct {
    logic [9:0] v;
    string      tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_reg_waddr;
  logic          id_rs1_used, id_rs2_used, ex_is_load, ex_reg_wen;
  logic          ex_branch_taken, mem_req, mem_ack, wb_ebreak;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, mem_wb_en, mem_wb_bubble, halt, fault;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model status, advanced once per clock by the driver.
  bit m_halted = 0, m_faulted = 0, m_waiting = 0;
  int m_wcnt = 0;
  bit n_halted = 0, n_faulted = 0, n_waiting = 0;
  int n_wcnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1_addr_i     (id_rs1_addr),
    .id_rs2_addr_i     (id_rs2_addr),
    .id_rs1_used_i     (id_rs1_used),
    .id_rs2_used_i     (id_rs2_used),
    .ex_is_load_i      (ex_is_load),
    .ex_reg_wen_i      (ex_reg_wen),
    .ex_reg_waddr_i    (ex_reg_waddr),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_req_i         (mem_req),
    .mem_ack_i         (mem_ack),
    .wb_ebreak_i       (wb_ebreak),
    .pc_en_o           (pc_en),
    .if_id_en_o        (if_id_en),
    .if_id_flush_o     (if_id_flush),
    .id_ex_en_o        (id_ex_en),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_en_o       (ex_mem_en),
    .mem_wb_en_o       (mem_wb_en),
    .mem_wb_bubble_o   (mem_wb_bubble),
    .halt_o            (halt),
    .fault_o           (fault)
  );

  // Output vector order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb, bubble, halt, fault
  function automatic logic [9:0] normal_flow(input stim_t s);
    bit hz;
    hz = s.is_load && s.wen && (s.waddr != 0) &&
         ((s.u1 && s.rs1 == s.waddr) || (s.u2 && s.rs2 == s.waddr));
    if (s.br)  return 10'b1_1_1_1_1_1_1_0_0_0;
    if (hz)    return 10'b0_0_0_1_1_1_1_0_0_0;
    return 10'b1_1_0_1_0_1_1_0_0_0;
  endfunction

  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    m_halted = n_halted; m_faulted = n_faulted; m_waiting = n_waiting; m_wcnt = n_wcnt;
    rst = s.rst; id_rs1_addr = s.rs1; id_rs2_addr = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_is_load = s.is_load;
    ex_reg_wen = s.wen; ex_reg_waddr = s.waddr; ex_branch_taken = s.br;
    mem_req = s.req; mem_ack = s.ack; wb_ebreak = s.ebreak;
    if (s.rst) begin
      e.v = 10'b0_0_1_0_1_0_0_1_0_0;
      n_halted = 0; n_faulted = 0; n_waiting = 0; n_wcnt = 0;
    end else if (m_halted) begin
      e.v = {9'b0, 1'b0} | 10'b0_0_0_0_0_0_0_0_1_0 | {9'b0, m_faulted};
    end else if (!m_waiting) begin
      if (s.ebreak) begin
        e.v = 10'b0; n_halted = 1;
      end else if (s.req && !s.ack) begin
        e.v = 10'b0_0_0_0_0_0_0_1_0_0; n_waiting = 1; n_wcnt = 1;
      end else begin
        e.v = normal_flow(s);
      end
    end else begin
      if (s.ack) begin
        e.v = normal_flow(s); n_waiting = 0;
      end else if (m_wcnt >= TMO) begin
        e.v = 10'b0_0_0_0_0_0_0_1_1_1; n_halted = 1; n_faulted = 1; n_waiting = 0;
      end else begin
        e.v = 10'b0_0_0_0_0_0_0_1_0_0; n_wcnt = m_wcnt + 1;
      end
    end
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: every cycle the driver presents a stimulus, check the response mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [9:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_en, mem_wb_bubble, halt, fault};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s t=%0t got=%b expected=%b", e.tag, $time, got, e.v);
      end
    end
  end

  function automatic stim_t rand_stim(input bit allow_rst);
    stim_t s;
    s.rst     = allow_rst && ($urandom_range(0, 31) == 0);
    s.rs1     = AW'($urandom_range(0, 3));
    s.rs2     = AW'($urandom_range(0, 3));
    s.u1      = 1'($urandom);
    s.u2      = 1'($urandom);
    s.is_load = 1'($urandom);
    s.wen     = ($urandom_range(0, 3) != 0);
    s.waddr   = AW'($urandom_range(0, 3));
    s.br      = ($urandom_range(0, 5) == 0);
    s.req     = ($urandom_range(0, 3) == 0);
    s.ack     = 1'($urandom);
    s.ebreak  = ($urandom_range(0, 63) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    apply(s, "reset0");
    apply(s, "reset1");
    s.rst = 1'b0;
    apply(s, "run_idle");

    s.is_load = 1; s.wen = 1; s.waddr = 5; s.rs2 = 5; s.u2 = 1;
    apply(s, "lu_stall");
    s.is_load = 0;
    apply(s, "lu_release");
    s.is_load = 1; s.waddr = 0; s.rs2 = 0;
    apply(s, "lu_x0");

    s.waddr = 5; s.rs2 = 5; s.br = 1;
    apply(s, "branch_lu");
    s = '0;

    s.req = 1;
    repeat (3) apply(s, "mem_wait");
    s.ack = 1;
    apply(s, "mem_ack");
    s = '0;
    apply(s, "mem_done");
    s.req = 1; s.ack = 1;
    apply(s, "mem_same_cycle");

    s = '0; s.req = 1;
    apply(s, "ack_at_limit_req");
    repeat (3) apply(s, "ack_at_limit_wait");
    s.ack = 1;
    apply(s, "ack_at_limit");
    s = '0;
    apply(s, "ack_at_limit_after");

    s.req = 1;
    repeat (5) apply(s, "timeout");
    s.req = 0;
    repeat (2) apply(s, "fault_hold");
    s.rst = 1;
    apply(s, "fault_reset");
    s.rst = 0;
    apply(s, "fault_resume");

    s.br = 1; s.ebreak = 1;
    apply(s, "ebreak_branch");
    for (int i = 0; i < 10; i++) apply(rand_stim(1'b0), "halt_hold");
    s = '0; s.rst = 1;
    apply(s, "halt_reset");
    s.rst = 0;
    apply(s, "halt_resume");

    for (int i = 0; i < 2000; i++) apply(rand_stim(1'b1), "random");

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
